// File: rtl/event_wakeup_pkg.sv
// Shared constants and types for the event/wakeup controller.
package event_wakeup_pkg;

    // APB register word offsets
    localparam logic [7:0] OFF_MASK    = 8'h00;
    localparam logic [7:0] OFF_PENDING = 8'h04;
    localparam logic [7:0] OFF_TCMP    = 8'h08;
    localparam logic [7:0] OFF_TCTRL   = 8'h0C;
    localparam logic [7:0] OFF_TCNT    = 8'h10;

    // TIMER_CTRL bit positions
    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_AR_BIT = 1;

    // Event delivery handshake states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CLEAR = 2'd2
    } ewu_state_e;

endpackage

// File: rtl/wakeup_timer.sv
// Free-running compare timer: counts while enabled, pulses match for one
// cycle when the count reaches the compare value, then restarts from 0.
module wakeup_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        autoreload_i,
    input  logic        clr_i,
    input  logic [31:0] cmp_i,
    output logic        match_o,
    output logic        stop_o,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q, cnt_d;

    // A compare value of zero disables matching entirely.
    assign match_o = en_i && (cmp_i != 32'd0) && (cnt_q == cmp_i);
    // One-shot mode asks the owner of TIMER_CTRL to drop the enable bit.
    assign stop_o  = match_o && !autoreload_i;
    assign cnt_o   = cnt_q;

    // Next count: register writes and zero compare hold/force 0, match wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cmp_i == 32'd0) || match_o)
            cnt_d = 32'd0;
        else if (en_i)
            cnt_d = cnt_q + 32'd1;
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= 32'd0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/event_wakeup_ctrl.sv
// Event/wakeup controller: latches rising edges of external events plus a
// timer match into PENDING, raises wakeup on any enabled pending bit, and
// hands enabled events to the core one at a time, lowest index first.
module event_wakeup_ctrl
    import event_wakeup_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_EXT_EVENTS   = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_EXT_EVENTS-1:0]   event_i,
    output logic                      event_valid_o,
    output logic [4:0]                event_id_o,
    input  logic                      event_ack_i,
    output logic                      wakeup_o
);

    localparam int NP = N_EXT_EVENTS + 1;  // external lines plus timer bit

    logic [NP-1:0]           mask_q, mask_d, pend_q, pend_d, pend_sw;
    logic [NP-1:0]           set_vec, w1c_vec, ack_vec, req, id_vec;
    logic [31:0]             cmp_q, cmp_d, tcnt;
    logic [1:0]              ctrl_q, ctrl_d;
    logic [N_EXT_EVENTS-1:0] ev_q, rise;
    logic                    armed_q, wake_q;
    logic                    wr_en, rd_en, tmr_match, tmr_stop, tmr_clr, ack_take;
    logic [4:0]              id_q, id_d, low_idx;
    ewu_state_e              state_q, state_d;

    logic sel_mask, sel_pend, sel_tcmp, sel_tctrl, sel_tcnt;

    assign wr_en     = PSEL && PENABLE && PWRITE;
    assign rd_en     = PSEL && PENABLE && !PWRITE;
    assign sel_mask  = (PADDR == APB_ADDR_WIDTH'(OFF_MASK));
    assign sel_pend  = (PADDR == APB_ADDR_WIDTH'(OFF_PENDING));
    assign sel_tcmp  = (PADDR == APB_ADDR_WIDTH'(OFF_TCMP));
    assign sel_tctrl = (PADDR == APB_ADDR_WIDTH'(OFF_TCTRL));
    assign sel_tcnt  = (PADDR == APB_ADDR_WIDTH'(OFF_TCNT));
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;

    // armed_q masks the first cycle after reset so lines already high are
    // not mistaken for fresh edges.
    assign rise    = armed_q ? (event_i & ~ev_q) : '0;
    assign set_vec = {tmr_match, rise};
    assign w1c_vec = (wr_en && sel_pend) ? PWDATA[NP-1:0] : '0;
    assign mask_d  = (wr_en && sel_mask) ? PWDATA[NP-1:0] : mask_q;
    assign cmp_d   = (wr_en && sel_tcmp) ? PWDATA : cmp_q;
    assign tmr_clr = wr_en && (sel_tcmp || sel_tctrl);
    assign id_vec  = NP'(1) << id_q;
    assign ack_vec = ack_take ? id_vec : '0;
    // Hardware sets are OR'd in last so they win over any same-cycle clear.
    assign pend_sw = (pend_q & ~w1c_vec) | set_vec;
    assign pend_d  = (pend_sw & ~ack_vec) | set_vec;
    assign req     = pend_q & mask_q;

    // TIMER_CTRL: software write wins; one-shot match drops the enable bit
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_en && sel_tctrl)
            ctrl_d = PWDATA[1:0];
        else if (tmr_stop)
            ctrl_d[CTRL_EN_BIT] = 1'b0;
    end

    wakeup_timer u_timer (
        .clk_i        (HCLK),
        .rst_i        (HRESET),
        .en_i         (ctrl_q[CTRL_EN_BIT]),
        .autoreload_i (ctrl_q[CTRL_AR_BIT]),
        .clr_i        (tmr_clr),
        .cmp_i        (cmp_q),
        .match_o      (tmr_match),
        .stop_o       (tmr_stop),
        .cnt_o        (tcnt)
    );

    // Lowest-index priority encoder; scanning downward lets the lowest hit win
    always_comb begin
        low_idx = 5'd0;
        for (int i = NP - 1; i >= 0; i--)
            if (req[i]) low_idx = 5'(i);
    end

    // Register file, edge history and registered wakeup
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mask_q  <= '0;
            pend_q  <= '0;
            cmp_q   <= 32'd0;
            ctrl_q  <= 2'd0;
            ev_q    <= '0;
            armed_q <= 1'b0;
            wake_q  <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            ev_q    <= event_i;
            armed_q <= 1'b1;
            wake_q  <= |(pend_q & mask_q);
        end
    end

    // FSM state register with the latched grant index
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            id_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // FSM next state; a grant is withdrawn if software clears its pending
    // or mask bit this cycle, so no ack is ever needed for a dead event
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    id_d    = low_idx;
                end
            end
            ST_GRANT: begin
                if ((pend_sw & mask_d & id_vec) == '0) begin
                    state_d = ST_IDLE;
                end else if (event_ack_i) begin
                    state_d  = ST_CLEAR;
                    ack_take = 1'b1;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        event_valid_o = (state_q == ST_GRANT);
        event_id_o    = id_q;
        wakeup_o      = wake_q;
    end

    // APB read mux, zero outside an access phase or during reset
    always_comb begin
        PRDATA = 32'd0;
        if (rd_en && !HRESET) begin
            if (sel_mask)  PRDATA = 32'(mask_q);
            if (sel_pend)  PRDATA = 32'(pend_q);
            if (sel_tcmp)  PRDATA = cmp_q;
            if (sel_tctrl) PRDATA = 32'(ctrl_q);
            if (sel_tcnt)  PRDATA = tcnt;
        end
    end

endmodule

// File: tb/tb_event_wakeup_ctrl.sv
// Directed bench for event_wakeup_ctrl: edge capture, masking, grant order,
// software withdrawal, timer periodic/one-shot, and reset behaviour.
module tb_event_wakeup_ctrl;

    localparam logic [11:0] A_MASK  = 12'h000;
    localparam logic [11:0] A_PEND  = 12'h004;
    localparam logic [11:0] A_TCMP  = 12'h008;
    localparam logic [11:0] A_TCTRL = 12'h00C;
    localparam logic [11:0] A_TCNT  = 12'h010;

    logic        HCLK, HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [7:0]  event_i;
    logic        event_valid_o, event_ack_i, wakeup_o;
    logic [4:0]  event_id_o;

    int n_chk  = 0;
    int n_fail = 0;

    event_wakeup_ctrl #(.APB_ADDR_WIDTH(12), .N_EXT_EVENTS(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .event_i(event_i),
        .event_valid_o(event_valid_o), .event_id_o(event_id_o),
        .event_ack_i(event_ack_i), .wakeup_o(wakeup_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        cyc();
        PENABLE = 1'b1;
        cyc();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        cyc();
        PENABLE = 1'b1;
        #1;
        chk(tag, PRDATA, exp);
        cyc();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic hold_read(input logic [11:0] a);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
    endtask

    task automatic release_bus();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    initial begin
        HRESET = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0;
        PENABLE = 1'b0; event_i = '0; event_ack_i = 1'b0;

        // Reset applies before any clock edge
        #1 HRESET = 1'b1;
        #1;
        chk("rst_valid",  {31'd0, event_valid_o}, 32'd0);
        chk("rst_id",     {27'd0, event_id_o},    32'd0);
        chk("rst_wakeup", {31'd0, wakeup_o},      32'd0);
        chk("rst_prdata", PRDATA,                 32'd0);
        cyc(); cyc();
        HRESET = 1'b0;
        cyc();
        chk("pready",  {31'd0, PREADY},  32'd1);
        chk("pslverr", {31'd0, PSLVERR}, 32'd0);
        rd_chk("rst_pending", A_PEND, 32'd0);
        rd_chk("bad_offset",  12'h014, 32'd0);

        // Two simultaneous edges, lowest index first, CLEAR+IDLE gap
        apb_wr(A_MASK, 32'h05);
        event_i = 8'h05;
        cyc();
        event_i = 8'h00;
        cyc();
        chk("t30_valid0",  {31'd0, event_valid_o}, 32'd1);
        chk("t30_id0",     {27'd0, event_id_o},    32'd0);
        chk("t30_wake",    {31'd0, wakeup_o},      32'd1);
        event_ack_i = 1'b1;
        cyc();
        event_ack_i = 1'b0;
        chk("t30_gap_clr", {31'd0, event_valid_o}, 32'd0);
        cyc();
        chk("t30_gap_idle", {31'd0, event_valid_o}, 32'd0);
        cyc();
        chk("t30_valid2",  {31'd0, event_valid_o}, 32'd1);
        chk("t30_id2",     {27'd0, event_id_o},    32'd2);
        event_ack_i = 1'b1;
        cyc();
        event_ack_i = 1'b0;
        chk("t30_done_valid", {31'd0, event_valid_o}, 32'd0);
        cyc();
        chk("t30_wake_off", {31'd0, wakeup_o}, 32'd0);
        rd_chk("t30_pending", A_PEND, 32'd0);

        // Masked event stays pending, unmasking wakes and grants it
        apb_wr(A_MASK, 32'h00);
        event_i = 8'h08;
        cyc(); cyc();
        rd_chk("t31_pending", A_PEND, 32'h08);
        chk("t31_wake0",  {31'd0, wakeup_o},      32'd0);
        chk("t31_valid0", {31'd0, event_valid_o}, 32'd0);
        apb_wr(A_MASK, 32'h08);
        chk("t31_wake_lag", {31'd0, wakeup_o}, 32'd0);
        cyc();
        chk("t31_wake1",  {31'd0, wakeup_o},      32'd1);
        chk("t31_valid1", {31'd0, event_valid_o}, 32'd1);
        chk("t31_id3",    {27'd0, event_id_o},    32'd3);
        event_ack_i = 1'b1;
        cyc();
        event_ack_i = 1'b0;
        event_i = 8'h00;
        cyc(); cyc();

        // Software W1C of the granted bit withdraws the grant
        apb_wr(A_MASK, 32'h10);
        event_i = 8'h10;
        cyc();
        event_i = 8'h00;
        cyc();
        chk("t35_valid1", {31'd0, event_valid_o}, 32'd1);
        chk("t35_id4",    {27'd0, event_id_o},    32'd4);
        apb_wr(A_PEND, 32'h10);
        chk("t35_valid0", {31'd0, event_valid_o}, 32'd0);
        cyc();
        chk("t35_stay0",  {31'd0, event_valid_o}, 32'd0);
        rd_chk("t35_pending", A_PEND, 32'd0);

        // Hardware set beats a same-cycle W1C; ack outside GRANT is ignored
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_PEND; PWDATA = 32'h02;
        cyc();
        PENABLE = 1'b1;
        event_i = 8'h02;
        cyc();
        release_bus();
        event_i = 8'h00;
        rd_chk("t33_pending", A_PEND, 32'h02);
        event_ack_i = 1'b1;
        cyc();
        event_ack_i = 1'b0;
        rd_chk("ack_idle_pending", A_PEND, 32'h02);
        chk("ack_idle_valid", {31'd0, event_valid_o}, 32'd0);
        apb_wr(A_PEND, 32'h02);
        rd_chk("t33_cleared", A_PEND, 32'd0);

        // Auto-reload timer: CMP=4 sets the timer bit every 5 cycles
        apb_wr(A_TCMP, 32'd4);
        apb_wr(A_TCTRL, 32'h3);
        hold_read(A_PEND);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("t32_ar_first", PRDATA, (i == 5) ? 32'h100 : 32'h0);
        end
        release_bus();
        apb_wr(A_PEND, 32'h100);
        hold_read(A_PEND);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("t32_ar_second", PRDATA, (i == 3) ? 32'h100 : 32'h0);
        end
        release_bus();

        // One-shot timer fires once and drops its own enable
        apb_wr(A_PEND, 32'h100);
        apb_wr(A_TCTRL, 32'h1);
        hold_read(A_PEND);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("t32_os", PRDATA, (i == 5) ? 32'h100 : 32'h0);
        end
        release_bus();
        rd_chk("t32_os_ctrl", A_TCTRL, 32'h0);
        rd_chk("t32_os_cnt",  A_TCNT,  32'h0);
        apb_wr(A_PEND, 32'h100);
        repeat (8) cyc();
        rd_chk("t32_os_no_refire", A_PEND, 32'h0);

        // Zero compare holds the counter and never matches
        apb_wr(A_TCMP, 32'd0);
        apb_wr(A_TCTRL, 32'h1);
        repeat (6) cyc();
        rd_chk("cmp0_cnt",  A_TCNT,  32'h0);
        rd_chk("cmp0_ctrl", A_TCTRL, 32'h1);
        rd_chk("cmp0_pend", A_PEND,  32'h0);
        apb_wr(A_TCTRL, 32'h0);

        // Reset mid-GRANT with the line held high
        apb_wr(A_MASK, 32'h40);
        event_i = 8'h40;
        cyc(); cyc();
        chk("t34_valid_pre", {31'd0, event_valid_o}, 32'd1);
        chk("t34_id_pre",    {27'd0, event_id_o},    32'd6);
        HRESET = 1'b1;
        #1;
        chk("t34_valid_rst", {31'd0, event_valid_o}, 32'd0);
        chk("t34_id_rst",    {27'd0, event_id_o},    32'd0);
        chk("t34_wake_rst",  {31'd0, wakeup_o},      32'd0);
        cyc();
        HRESET = 1'b0;
        cyc();
        apb_wr(A_MASK, 32'h40);
        cyc(); cyc();
        chk("t34_no_grant", {31'd0, event_valid_o}, 32'd0);
        chk("t34_no_wake",  {31'd0, wakeup_o},      32'd0);
        rd_chk("t34_pending", A_PEND, 32'd0);
        event_i = 8'h00;
        cyc();
        event_i = 8'h40;
        cyc(); cyc();
        chk("t34_new_edge_valid", {31'd0, event_valid_o}, 32'd1);
        chk("t34_new_edge_id",    {27'd0, event_id_o},    32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
